alu_sequencer: RTL and testbench

- Initiator side of the ALU operation interface: accepts one decoded RV64I integer instruction per valid/ready handshake.
- Translates opcode/funct3/funct7 into the ALU's 6-bit operation code and drives the ALU operands from registers.
- Captures the ALU result and flags, then presents a registered response (result, branch decision, illegal, overflow) with a valid/ready handshake.
- Sits between instruction decode and writeback/PC-update; the ALU itself is instantiated beside it, not inside it.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_op_decoder.sv | 57 +++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU operation interface: ALU op codes, RV64I opcodes,
// branch funct3 encodings and the sequencer state type.
package alu_pkg;

  localparam logic [5:0] AluAdd = 6'b00_0000;
  localparam logic [5:0] AluSub = 6'b00_0001;
  localparam logic [5:0] AluAnd = 6'b10_0000;
  localparam logic [5:0] AluOr  = 6'b10_0001;
  localparam logic [5:0] AluXor = 6'b10_0011;
  localparam logic [5:0] AluSra = 6'b11_0000;
  localparam logic [5:0] AluSrl = 6'b11_0010;
  localparam logic [5:0] AluSll = 6'b11_0011;

  localparam logic [6:0] OpcOp     = 7'b011_0011;
  localparam logic [6:0] OpcOpImm  = 7'b001_0011;
  localparam logic [6:0] OpcBranch = 7'b110_0011;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    BSelRs2   = 2'd0,
    BSelImm   = 2'd1,
    BSelShamt = 2'd2
  } b_sel_e;

  function automatic logic branch_decision(input logic [2:0] f3, input logic eq,
                                           input logic lt, input logic ltu);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3Beq:   taken = eq;
      F3Bne:   taken = !eq;
      F3Blt:   taken = lt;
      F3Bge:   taken = !lt;
      F3Bltu:  taken = ltu;
      F3Bgeu:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of opcode/funct3/funct7 into ALU operation, operand-b source,
// branch marker and illegal flag.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [5:0] operation,
  output b_sel_e     b_sel,
  output logic       is_branch,
  output logic       illegal
);

  logic is_imm;
  logic unused_funct7;

  assign is_imm        = (opcode == OpcOpImm);
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    operation = AluAdd;
    b_sel     = BSelRs2;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OpcOp, OpcOpImm: begin
        b_sel = is_imm ? BSelImm : BSelRs2;
        case (funct3)
          // Immediate form has no subtract; funct7 only selects sub for register form.
          3'b000:  operation = (!is_imm && funct7[5]) ? AluSub : AluAdd;
          3'b100:  operation = AluXor;
          3'b110:  operation = AluOr;
          3'b111:  operation = AluAnd;
          3'b001: begin
            operation = AluSll;
            b_sel     = is_imm ? BSelShamt : BSelRs2;
          end
          3'b101: begin
            operation = funct7[5] ? AluSra : AluSrl;
            b_sel     = is_imm ? BSelShamt : BSelRs2;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpcBranch: begin
        operation = AluSub;
        is_branch = 1'b1;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator side of the ALU operation interface: decodes one RV64I integer instruction,
// drives registered ALU operands, captures the result and returns a registered response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [WORDSIZE-1:0] in_rs1,
  input  logic [WORDSIZE-1:0] in_rs2,
  input  logic [WORDSIZE-1:0] in_imm,
  output logic [WORDSIZE-1:0] alu_input_a,
  output logic [WORDSIZE-1:0] alu_input_b,
  output logic [5:0]          alu_operation,
  input  logic [WORDSIZE-1:0] alu_result,
  input  logic                alu_flag_overflow,
  input  logic                alu_flag_equal,
  input  logic                alu_flag_less,
  input  logic                alu_flag_u_less,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_result,
  output logic                out_branch_taken,
  output logic                out_illegal,
  output logic                out_overflow
);

  seq_state_e          state_q, state_d;
  logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [5:0]          op_q, op_d;
  logic [2:0]          br_f3_q, br_f3_d;
  logic                is_branch_q, is_branch_d;
  logic                taken_q, taken_d, illegal_q, illegal_d, overflow_q, overflow_d;

  logic [5:0]          dec_op;
  b_sel_e              dec_b_sel;
  logic                dec_is_branch, dec_illegal;
  logic [WORDSIZE-1:0] b_mux;

  alu_op_decoder u_decoder (
    .opcode    (in_opcode),
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .operation (dec_op),
    .b_sel     (dec_b_sel),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  always_comb begin
    case (dec_b_sel)
      BSelImm:   b_mux = in_imm;
      BSelShamt: b_mux = {{(WORDSIZE-6){1'b0}}, in_imm[5:0]};
      default:   b_mux = in_rs2;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    br_f3_d     = br_f3_q;
    is_branch_d = is_branch_q;
    result_d    = result_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    overflow_d  = overflow_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d         = in_rs1;
          b_d         = b_mux;
          op_d        = dec_op;
          br_f3_d     = in_funct3;
          is_branch_d = dec_is_branch && !dec_illegal;
          result_d    = '0;
          taken_d     = 1'b0;
          overflow_d  = 1'b0;
          illegal_d   = dec_illegal;
          // Illegal encodings skip the ALU and answer with a zeroed response.
          state_d     = dec_illegal ? StResp : StExec;
        end
      end
      StExec: begin
        result_d   = alu_result;
        overflow_d = alu_flag_overflow;
        taken_d    = is_branch_q &&
                     branch_decision(br_f3_q, alu_flag_equal, alu_flag_less, alu_flag_u_less);
        state_d    = StResp;
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= AluAdd;
      br_f3_q     <= '0;
      is_branch_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      br_f3_q     <= br_f3_d;
      is_branch_q <= is_branch_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready         = (state_q == StIdle);
  assign out_valid        = (state_q == StResp);
  assign alu_input_a      = a_q;
  assign alu_input_b      = b_q;
  assign alu_operation    = op_q;
  assign out_result       = result_q;
  assign out_branch_taken = taken_q;
  assign out_illegal      = illegal_q;
  assign out_overflow     = overflow_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU placed beside it.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [63:0] in_rs1, in_rs2, in_imm;
  logic [63:0] alu_input_a, alu_input_b, alu_result;
  logic [5:0]  alu_operation;
  logic        alu_flag_overflow, alu_flag_equal, alu_flag_less, alu_flag_u_less;
  logic        out_valid, out_ready, out_branch_taken, out_illegal, out_overflow;
  logic [63:0] out_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WORDSIZE(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_opcode         (in_opcode),
    .in_funct3         (in_funct3),
    .in_funct7         (in_funct7),
    .in_rs1            (in_rs1),
    .in_rs2            (in_rs2),
    .in_imm            (in_imm),
    .alu_input_a       (alu_input_a),
    .alu_input_b       (alu_input_b),
    .alu_operation     (alu_operation),
    .alu_result        (alu_result),
    .alu_flag_overflow (alu_flag_overflow),
    .alu_flag_equal    (alu_flag_equal),
    .alu_flag_less     (alu_flag_less),
    .alu_flag_u_less   (alu_flag_u_less),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_branch_taken  (out_branch_taken),
    .out_illegal       (out_illegal),
    .out_overflow      (out_overflow)
  );

  // Reference ALU driven by the sequencer's registered operands.
  always_comb begin
    alu_result        = '0;
    alu_flag_overflow = 1'b0;
    alu_flag_equal    = (alu_input_a == alu_input_b);
    alu_flag_less     = ($signed(alu_input_a) < $signed(alu_input_b));
    alu_flag_u_less   = (alu_input_a < alu_input_b);
    case (alu_operation)
      AluAdd: begin
        alu_result        = alu_input_a + alu_input_b;
        alu_flag_overflow = (alu_input_a[63] == alu_input_b[63]) &&
                            (alu_result[63] != alu_input_a[63]);
      end
      AluSub: begin
        alu_result        = alu_input_a - alu_input_b;
        alu_flag_overflow = (alu_input_a[63] != alu_input_b[63]) &&
                            (alu_result[63] != alu_input_a[63]);
      end
      AluAnd:  alu_result = alu_input_a & alu_input_b;
      AluOr:   alu_result = alu_input_a | alu_input_b;
      AluXor:  alu_result = alu_input_a ^ alu_input_b;
      AluSll:  alu_result = alu_input_a << alu_input_b[5:0];
      AluSrl:  alu_result = alu_input_a >> alu_input_b[5:0];
      AluSra:  alu_result = $unsigned($signed(alu_input_a) >>> alu_input_b[5:0]);
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and let it be accepted on the next edge.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
    check("in_ready_before_issue", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    tick();
    in_valid = 1'b0;
  endtask

  // Legal instruction: EXEC after accept, response one edge later, then drain.
  task automatic run_legal(input string tag, input logic [63:0] exp_result,
                           input logic exp_taken, input logic exp_ovf);
    check({tag, "_exec_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_exec_ready"}, 64'(in_ready), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, out_result, exp_result);
    check({tag, "_taken"}, 64'(out_branch_taken), 64'(exp_taken));
    check({tag, "_illegal"}, 64'(out_illegal), 64'd0);
    check({tag, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
    tick();
    check({tag, "_back_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_op", 64'(alu_operation), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_alu_a", alu_input_a, 64'd0);
    tick();

    // R-type sub: 10 - 3
    issue(OpcOp, 3'b000, 7'b0100000, 64'd10, 64'd3, 64'd0);
    check("sub_op", 64'(alu_operation), 64'(6'b000001));
    check("sub_a", alu_input_a, 64'd10);
    check("sub_b", alu_input_b, 64'd3);
    run_legal("sub", 64'd7, 1'b0, 1'b0);

    // I-type srai by 3 of -16
    issue(OpcOpImm, 3'b101, 7'b0100000, 64'hFFFF_FFFF_FFFF_FFF0, 64'd99, 64'h403);
    check("srai_op", 64'(alu_operation), 64'(6'b110000));
    check("srai_b", alu_input_b, 64'd3);
    run_legal("srai", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    // slli: shamt taken from imm[5:0] only (0x44 -> 4)
    issue(OpcOpImm, 3'b001, 7'b0000001, 64'd1, 64'd0, 64'h44);
    check("slli_op", 64'(alu_operation), 64'(6'b110011));
    check("slli_b", alu_input_b, 64'd4);
    run_legal("slli", 64'd16, 1'b0, 1'b0);

    // xori
    issue(OpcOpImm, 3'b100, 7'b0000000, 64'h0F, 64'd0, 64'hFF);
    check("xori_op", 64'(alu_operation), 64'(6'b100011));
    check("xori_b", alu_input_b, 64'hFF);
    run_legal("xori", 64'hF0, 1'b0, 1'b0);

    // addi ignores funct7[5]
    issue(OpcOpImm, 3'b000, 7'b0100000, 64'd5, 64'd0, 64'd2);
    check("addi_op", 64'(alu_operation), 64'(6'b000000));
    run_legal("addi", 64'd7, 1'b0, 1'b0);

    // add signed overflow
    issue(OpcOp, 3'b000, 7'b0000000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    run_legal("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // bltu vs blt with rs1 = all ones, rs2 = 1
    issue(OpcBranch, F3Bltu, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    check("bltu_op", 64'(alu_operation), 64'(6'b000001));
    run_legal("bltu", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue(OpcBranch, F3Blt, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    run_legal("blt", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    issue(OpcBranch, F3Beq, 7'b0000000, 64'd5, 64'd5, 64'd0);
    run_legal("beq", 64'd0, 1'b1, 1'b0);
    issue(OpcBranch, F3Bne, 7'b0000000, 64'd5, 64'd5, 64'd0);
    run_legal("bne", 64'd0, 1'b0, 1'b0);
    issue(OpcBranch, F3Bgeu, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    run_legal("bgeu", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

    // Backpressure: and held for 5 cycles while another instruction waits on the input
    out_ready = 1'b0;
    issue(OpcOp, 3'b111, 7'b0000000, 64'hF0F0, 64'hFF00, 64'd0);
    in_valid  = 1'b1;
    in_opcode = OpcOp;
    in_funct3 = 3'b110;
    in_funct7 = 7'b0000000;
    in_rs1    = 64'h0F;
    in_rs2    = 64'hF0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", out_result, 64'hF000);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp_second_op", 64'(alu_operation), 64'(6'b100001));
    run_legal("bp_second", 64'hFF, 1'b0, 1'b0);

    // Illegal slt on OP: response after one edge, zeroed
    issue(OpcOp, 3'b010, 7'b0000000, 64'd1, 64'd2, 64'd0);
    check("ill_valid", 64'(out_valid), 64'd1);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_result", out_result, 64'd0);
    check("ill_taken", 64'(out_branch_taken), 64'd0);
    tick();
    check("ill_back_idle", 64'(in_ready), 64'd1);

    // Illegal opcode and illegal branch funct3
    issue(7'b0110111, 3'b000, 7'b0000000, 64'd1, 64'd2, 64'd0);
    check("ill_opc_flag", 64'(out_illegal), 64'd1);
    tick();
    issue(OpcBranch, 3'b011, 7'b0000000, 64'd1, 64'd1, 64'd0);
    check("ill_br_flag", 64'(out_illegal), 64'd1);
    check("ill_br_taken", 64'(out_branch_taken), 64'd0);
    tick();

    // Reset while in EXEC drops the instruction
    issue(OpcOp, 3'b000, 7'b0100000, 64'd10, 64'd3, 64'd0);
    check("rexec_in_exec", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rexec_in_ready", 64'(in_ready), 64'd1);
    check("rexec_out_valid", 64'(out_valid), 64'd0);
    check("rexec_alu_op", 64'(alu_operation), 64'd0);
    tick();
    check("rexec_no_resp", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
